flash_addr_sequencer: RTL and testbench

FLASH_ADDR_SEQUENCER -- requirements
Module: flash_addr_sequencer

---
 rtl/flash_addr_sequencer_if.sv | 26 ++
 rtl/flash_addr_sequencer.sv | 171 +++++++++++++++++
 tb/tb_flash_addr_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_addr_sequencer_if.sv
// Flash read bus between the audio address sequencer (master) and the flash controller (slave).
interface flash_addr_sequencer_if #(
  parameter int ADDR_W = 23
);
  logic              flash_read;
  logic [ADDR_W-1:0] flash_address;
  logic              flash_waitrequest;
  logic [31:0]       flash_readdata;
  logic              flash_readdatavalid;

  modport master (
    output flash_read,
    output flash_address,
    input  flash_waitrequest,
    input  flash_readdata,
    input  flash_readdatavalid
  );

  modport slave (
    input  flash_read,
    input  flash_address,
    output flash_waitrequest,
    output flash_readdata,
    output flash_readdatavalid
  );
endinterface

// File: rtl/flash_addr_sequencer.sv
// Walks the flash word address of an audio clip, emitting two 16-bit samples per word on sample_tick.
// Optional readdatavalid watchdog enabled by defining FLASH_SEQ_TIMEOUT_EN.
module flash_addr_sequencer #(
  parameter int                ADDR_W      = 23,
  parameter logic [ADDR_W-1:0] MAX_ADDR    = 23'h7FFFF,
  parameter int                TIMEOUT_CYC = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pause,
  input  logic                          reverse,
  input  logic                          restart,
  input  logic                          sample_tick,
  flash_addr_sequencer_if.master        flash,
  output logic [15:0]                   audio_sample,
  output logic                          sample_valid
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    READ_REQ,
    WAIT_DATA,
    EMIT0,
    WAIT_TICK2,
    EMIT1,
    ADVANCE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] word_addr;
  logic [ADDR_W-1:0] step_addr;
  logic [ADDR_W-1:0] restart_addr;
  logic [31:0]       word_latch;
  logic              rev_latched;
  logic              restart_pending;
  logic              restart_now;
  logic              tick_go;
  logic              timed_out;

  assign flash.flash_address = word_addr;
  assign restart_now         = restart_pending | restart;
  assign tick_go             = sample_tick & ~pause;
  assign restart_addr        = reverse ? MAX_ADDR : '0;

  always_comb begin
    step_addr = word_addr + ADDR_ONE;
    if (reverse) begin
      step_addr = (word_addr == '0) ? MAX_ADDR : (word_addr - ADDR_ONE);
    end else if (word_addr == MAX_ADDR) begin
      step_addr = '0;
    end
  end

`ifdef FLASH_SEQ_TIMEOUT_EN
  // Watchdog counts cycles spent in WAIT_DATA; the last count abandons the word.
  localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  logic [WD_W-1:0] wd_cnt;

  assign timed_out = (state == WAIT_DATA) && !flash.flash_readdatavalid && (wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (reset || state != WAIT_DATA || flash.flash_readdatavalid) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_ONE;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  // Restart is sticky and only takes effect in the three "safe" states, ahead of any tick or step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      word_addr        <= '0;
      word_latch       <= '0;
      rev_latched      <= 1'b0;
      restart_pending  <= 1'b0;
      flash.flash_read <= 1'b0;
      audio_sample     <= 16'h0000;
      sample_valid     <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (restart) begin
        restart_pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          state <= WAIT_TICK;
        end

        WAIT_TICK: begin
          if (restart_now) begin
            word_addr       <= restart_addr;
            restart_pending <= 1'b0;
          end else if (tick_go) begin
            flash.flash_read <= 1'b1;
            state            <= READ_REQ;
          end
        end

        READ_REQ: begin
          if (!flash.flash_waitrequest) begin
            flash.flash_read <= 1'b0;
            state            <= WAIT_DATA;
          end
        end

        // A word that lands while a restart is pending is dropped without a sample pulse.
        WAIT_DATA: begin
          if (flash.flash_readdatavalid) begin
            if (restart_now) begin
              state <= WAIT_TICK;
            end else begin
              word_latch   <= flash.flash_readdata;
              rev_latched  <= reverse;
              audio_sample <= reverse ? flash.flash_readdata[31:16] : flash.flash_readdata[15:0];
              sample_valid <= 1'b1;
              state        <= EMIT0;
            end
          end else if (timed_out) begin
            state <= ADVANCE;
          end
        end

        EMIT0: begin
          state <= WAIT_TICK2;
        end

        WAIT_TICK2: begin
          if (restart_now) begin
            word_addr       <= restart_addr;
            restart_pending <= 1'b0;
            state           <= WAIT_TICK;
          end else if (tick_go) begin
            audio_sample <= rev_latched ? word_latch[15:0] : word_latch[31:16];
            sample_valid <= 1'b1;
            state        <= EMIT1;
          end
        end

        EMIT1: begin
          state <= ADVANCE;
        end

        ADVANCE: begin
          if (restart_now) begin
            word_addr       <= restart_addr;
            restart_pending <= 1'b0;
          end else begin
            word_addr <= step_addr;
          end
          state <= WAIT_TICK;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_addr_sequencer.sv
// Scoreboard bench for flash_addr_sequencer: expected samples are queued when flash data is driven
// and popped whenever the DUT pulses sample_valid.
module tb_flash_addr_sequencer;

  logic clk;
  logic reset;
  logic pause;
  logic reverse;
  logic restart;
  logic sample_tick;
  logic [15:0] audio_sample;
  logic sample_valid;

  int checks;
  int errors;
  int valid_count;
  int vc;
  logic [15:0] exp_q[$];
  logic [15:0] exp_sample;
  logic [15:0] lo_half;
  logic [22:0] n_addr;

  flash_addr_sequencer_if #(.ADDR_W(23)) fbus ();

  flash_addr_sequencer #(
    .ADDR_W(23),
    .MAX_ADDR(23'h7FFFF),
    .TIMEOUT_CYC(255)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pause(pause),
    .reverse(reverse),
    .restart(restart),
    .sample_tick(sample_tick),
    .flash(fbus),
    .audio_sample(audio_sample),
    .sample_valid(sample_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Every sample pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && sample_valid) begin
      valid_count++;
      if (exp_q.size() == 0) begin
        checkOutput("spurious_valid", 32'(sample_valid), 32'd0);
      end else begin
        exp_sample = exp_q.pop_front();
        checkOutput("sample", 32'(audio_sample), 32'(exp_sample));
      end
    end
  end

  task automatic send_tick();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("queue_drain", 32'(exp_q.size()), 32'd0);
  endtask

  // mode 0: normal, 1: restart pulse while waiting (data dropped), 2: stray tick while waiting, 3: never respond
  task automatic serve_read(input logic [22:0] exp_addr, input logic [31:0] data, input int stalls, input int mode);
    int waited = 0;
    int hi_cycles = 0;
    while (!fbus.flash_read && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("read_seen", 32'(fbus.flash_read), 32'd1);
    if (!fbus.flash_read) return;
    checkOutput("read_addr", 32'(fbus.flash_address), 32'(exp_addr));
    for (int i = 0; i <= stalls; i++) begin
      if (fbus.flash_read && fbus.flash_address == exp_addr) hi_cycles++;
      if (i < stalls) @(negedge clk);
    end
    fbus.flash_waitrequest = 1'b0;
    @(negedge clk);
    fbus.flash_waitrequest = 1'b1;
    checkOutput("read_drop", 32'(fbus.flash_read), 32'd0);
    checkOutput("read_hold", 32'(hi_cycles), 32'(stalls + 1));
    if (mode == 1) begin
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
    end else if (mode == 2) begin
      send_tick();
    end else begin
      @(negedge clk);
    end
    if (mode != 3) begin
      if (mode != 1) begin
        if (reverse) begin
          exp_q.push_back(data[31:16]);
          exp_q.push_back(data[15:0]);
        end else begin
          exp_q.push_back(data[15:0]);
          exp_q.push_back(data[31:16]);
        end
      end
      fbus.flash_readdata = data;
      fbus.flash_readdatavalid = 1'b1;
      @(negedge clk);
      fbus.flash_readdatavalid = 1'b0;
      fbus.flash_readdata = $urandom;
    end
  endtask

  task automatic second_half();
    repeat (2) @(negedge clk);
    send_tick();
    repeat (3) @(negedge clk);
    wait_empty();
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    checks = 0;
    errors = 0;
    valid_count = 0;
    reset = 1'b1;
    pause = 1'b0;
    reverse = 1'b0;
    restart = 1'b0;
    sample_tick = 1'b0;
    fbus.flash_waitrequest = 1'b1;
    fbus.flash_readdata = 32'h0;
    fbus.flash_readdatavalid = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_read", 32'(fbus.flash_read), 32'd0);
    checkOutput("rst_addr", 32'(fbus.flash_address), 32'd0);
    checkOutput("rst_sample", 32'(audio_sample), 32'd0);
    checkOutput("rst_valid", 32'(sample_valid), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // First word, forward.
    send_tick();
    serve_read(23'h0, 32'hBBBB_AAAA, 0, 0);
    second_half();
    checkOutput("addr_fwd", 32'(fbus.flash_address), 32'h1);

    // Stalled request held for four cycles.
    send_tick();
    serve_read(23'h1, 32'h4444_3333, 3, 0);
    second_half();
    checkOutput("addr_stall", 32'(fbus.flash_address), 32'h2);

    // Tick during WAIT_DATA must not be queued for the second half.
    send_tick();
    vc = valid_count;
    serve_read(23'h2, 32'h6666_5555, 0, 2);
    repeat (5) @(negedge clk);
    checkOutput("stray_tick", 32'(valid_count), 32'(vc + 1));
    second_half();
    checkOutput("addr_stray", 32'(fbus.flash_address), 32'h3);

    // Pause asserted mid-read still emits the first half, then blocks the second.
    send_tick();
    pause = 1'b1;
    serve_read(23'h3, 32'h8888_7777, 1, 0);
    repeat (2) @(negedge clk);
    vc = valid_count;
    for (int i = 0; i < 5; i++) begin
      send_tick();
      @(negedge clk);
    end
    checkOutput("pause2_valid", 32'(valid_count), 32'(vc));
    checkOutput("pause2_hold", 32'(audio_sample), 32'h7777);
    pause = 1'b0;
    second_half();
    checkOutput("addr_pause2", 32'(fbus.flash_address), 32'h4);

    // Pause in WAIT_TICK: no reads, sample held, resume at the same address.
    pause = 1'b1;
    vc = valid_count;
    for (int i = 0; i < 5; i++) begin
      send_tick();
      @(negedge clk);
      checkOutput("pause_noread", 32'(fbus.flash_read), 32'd0);
    end
    checkOutput("pause_valid", 32'(valid_count), 32'(vc));
    checkOutput("pause_hold", 32'(audio_sample), 32'h8888);
    pause = 1'b0;
    send_tick();
    serve_read(23'h4, 32'h0F0F_F0F0, 0, 0);
    second_half();
    checkOutput("addr_resume", 32'(fbus.flash_address), 32'h5);

    // Restart beats a simultaneous tick.
    restart = 1'b1;
    sample_tick = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    sample_tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("restart_noread", 32'(fbus.flash_read), 32'd0);
    end
    checkOutput("addr_restart", 32'(fbus.flash_address), 32'h0);

    // Reverse from address 0 wraps to the end of the clip.
    reverse = 1'b1;
    @(negedge clk);
    send_tick();
    serve_read(23'h0, 32'h2222_1111, 0, 0);
    second_half();
    checkOutput("addr_rev_wrap", 32'(fbus.flash_address), 32'h7FFFF);

    // Forward from the last word wraps to 0.
    reverse = 1'b0;
    @(negedge clk);
    send_tick();
    serve_read(23'h7FFFF, 32'hDDDD_CCCC, 0, 0);
    second_half();
    checkOutput("addr_fwd_wrap", 32'(fbus.flash_address), 32'h0);

    // Stream 256 words with random stalls.
    for (int w = 0; w < 256; w++) begin
      lo_half = 16'(w) ^ 16'h5A00;
      send_tick();
      serve_read(23'(w), {~lo_half, lo_half}, int'($urandom_range(0, 2)), 0);
      second_half();
    end
    checkOutput("addr_stream", 32'(fbus.flash_address), 32'h100);

    // Restart during WAIT_DATA discards the word and reloads address 0.
    send_tick();
    vc = valid_count;
    serve_read(23'h100, 32'hEEEE_FFFF, 0, 1);
    repeat (4) @(negedge clk);
    checkOutput("discard_valid", 32'(valid_count), 32'(vc));
    checkOutput("discard_addr", 32'(fbus.flash_address), 32'h0);
    send_tick();
    serve_read(23'h0, 32'h1357_2468, 0, 0);
    second_half();
    checkOutput("addr_after_discard", 32'(fbus.flash_address), 32'h1);

    // Restart while reversing jumps to the clip end.
    reverse = 1'b1;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("addr_rev_restart", 32'(fbus.flash_address), 32'h7FFFF);
    reverse = 1'b0;
    @(negedge clk);
    n_addr = 23'h7FFFF;

`ifdef FLASH_SEQ_TIMEOUT_EN
    send_tick();
    vc = valid_count;
    serve_read(23'h7FFFF, 32'h0, 0, 3);
    repeat (300) @(negedge clk);
    checkOutput("timeout_addr", 32'(fbus.flash_address), 32'h0);
    checkOutput("timeout_valid", 32'(valid_count), 32'(vc));
    n_addr = 23'h0;
`endif

    // Reset mid-transaction; the late readdatavalid must be ignored.
    send_tick();
    serve_read(n_addr, 32'h0, 0, 3);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_read", 32'(fbus.flash_read), 32'd0);
    checkOutput("midrst_addr", 32'(fbus.flash_address), 32'd0);
    checkOutput("midrst_sample", 32'(audio_sample), 32'd0);
    checkOutput("midrst_valid", 32'(sample_valid), 32'd0);
    reset = 1'b0;
    vc = valid_count;
    fbus.flash_readdata = 32'hDEAD_BEEF;
    fbus.flash_readdatavalid = 1'b1;
    @(negedge clk);
    fbus.flash_readdatavalid = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("stale_valid", 32'(valid_count), 32'(vc));
    checkOutput("stale_sample", 32'(audio_sample), 32'd0);
    send_tick();
    serve_read(23'h0, 32'h0246_8ACE, 0, 0);
    second_half();
    checkOutput("addr_post_reset", 32'(fbus.flash_address), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
